// File: rtl/strip_pkg.sv
// Shared types for the LED-strip frame path: band/frame shapes, arbiter states
// and a width helper used by the arbiters that share the serializer.
package strip_pkg;

    localparam int BANDS = 40;
    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] band_t;
    typedef band_t frame_t [BANDS];

    typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_DRAIN, ARB_GAP} arb_state_t;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans from ptr_i+1 and returns the first
// requester found, as one-hot and as an index.
module rr_arbiter
    import strip_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = strip_pkg::idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/strip_frame_arbiter.sv
// Shares the parallel-to-serial strip serializer between NUM_REQ frame producers,
// one whole frame per grant, with an enforced latch gap after each frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for enable and a valid producer; arbitration live
// LOAD      | presenting the granted frame until the serializer takes it
// DRAIN     | serializer shifting out beats; waiting for the last beat
// GAP       | strip latch time; counting down before the next grant
module strip_frame_arbiter
#(
    parameter int NUM_REQ    = 2,
    parameter int BANDS      = strip_pkg::BANDS,
    parameter int WIDTH      = strip_pkg::WIDTH,
    parameter int GAP_CYCLES = 1000,
    localparam int IDX_W     = strip_pkg::idx_width(NUM_REQ),
    localparam int GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1,
    localparam int FRAME_W   = BANDS * WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [FRAME_W-1:0]         ser_in,
    output logic                       ser_s_valid,
    input  logic                       ser_s_ready,
    input  logic                       ser_m_valid,
    input  logic                       ser_m_ready,
    input  logic                       ser_m_last,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic [15:0]                frame_count
);
    import strip_pkg::*;

    localparam logic [1:0] S_IDLE  = 2'(ARB_IDLE);
    localparam logic [1:0] S_LOAD  = 2'(ARB_LOAD);
    localparam logic [1:0] S_DRAIN = 2'(ARB_DRAIN);
    localparam logic [1:0] S_GAP   = 2'(ARB_GAP);

    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        count_q, count_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               last_beat;

    logic [FRAME_W-1:0] frames [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_frame
        assign frames[r] = req_data[r*FRAME_W +: FRAME_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign last_beat = ser_m_valid && ser_m_ready && ser_m_last;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_d       = rr_q;
        gap_d      = gap_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE: begin
                if (enable && arb_any) begin
                    grant_d    = arb_idx;
                    grant_oh_d = arb_grant;
                    rr_d       = arb_idx;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ser_s_ready) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Backpressure only stretches this state; the last beat ends it.
                if (last_beat) begin
                    count_d = count_q + 16'd1;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_q       <= RR_INIT;
            gap_q      <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_q       <= rr_d;
            gap_q      <= gap_d;
            count_q    <= count_d;
        end
    end

    // The frame mux follows the registered grant so ser_in cannot glitch while presented.
    assign ser_s_valid = (state_q == S_LOAD);
    assign ser_in      = ser_s_valid ? frames[grant_q] : '0;
    assign req_ready   = (ser_s_valid && ser_s_ready) ? grant_oh_q : '0;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_strip_frame_arbiter.sv
// Bench for strip_frame_arbiter with a behavioural 40-band serializer and a
// frame-level round-robin reference model.
module tb_strip_frame_arbiter;
    import strip_pkg::*;

    localparam int NR  = 2;
    localparam int NB  = 40;
    localparam int W   = 16;
    localparam int GAP = 4;
    localparam int FW  = NB * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, enable;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*FW-1:0]  req_data;
    logic [FW-1:0]     ser_in;
    logic              ser_s_valid, ser_s_ready, ser_m_valid, ser_m_ready, ser_m_last;
    logic              busy;
    logic              grant_id;
    logic [15:0]       frame_count;

    strip_frame_arbiter #(
        .NUM_REQ    (NR),
        .BANDS      (NB),
        .WIDTH      (W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .ser_in      (ser_in),
        .ser_s_valid (ser_s_valid),
        .ser_s_ready (ser_s_ready),
        .ser_m_valid (ser_m_valid),
        .ser_m_ready (ser_m_ready),
        .ser_m_last  (ser_m_last),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_count (frame_count)
    );

    // Serializer: loads a frame when idle, shifts band 0 first, last on band 39.
    logic [FW-1:0] sh_q;
    logic [5:0]    pos_q;
    logic          act_q;
    logic          stall;
    logic [W-1:0]  ser_m_data;

    assign ser_s_ready = !act_q && !stall;
    assign ser_m_valid = act_q;
    assign ser_m_last  = act_q && (pos_q == 6'd39);
    assign ser_m_data  = sh_q[int'(pos_q)*W +: W];

    always @(posedge clk) begin
        if (!reset_n) begin
            act_q <= 1'b0;
            pos_q <= '0;
            sh_q  <= '0;
        end else if (!act_q) begin
            if (ser_s_valid && !stall) begin
                sh_q  <= ser_in;
                act_q <= 1'b1;
                pos_q <= '0;
            end
        end else if (ser_m_ready) begin
            if (pos_q == 6'd39) act_q <= 1'b0;
            else                pos_q <= pos_q + 6'd1;
        end
    end

    int           n_vec, n_err;
    int           rr_last;
    int           exp_count;
    logic [W-1:0] frm [NR][NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int last);
        for (int off = 1; off <= NR; off++) begin
            int c = (last + off) % NR;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    task automatic load_frame(input int i, input bit ramp);
        for (int b = 0; b < NB; b++) begin
            frm[i][b] = ramp ? W'(16'h100 + b) : W'($urandom);
            req_data[(i*NB + b)*W +: W] = frm[i][b];
        end
    endtask

    // bp: 0 = always ready, 1 = toggle every cycle, 2 = random
    task automatic run_frame(input int bp, input int drop_en_at, input int rst_at, input bit refill);
        int           id;
        int           b;
        int           bad;
        bit           seen;
        bit           done;
        logic [W-1:0] exp [NB];
        id = pick(req_valid, rr_last);
        for (int i = 0; i < NB; i++) exp[i] = frm[id][i];

        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            stall = ($urandom_range(0, 3) == 0);
            #1;
            if (ser_s_valid) begin
                bad = 0;
                for (int i = 0; i < NB; i++) if (ser_in[i*W +: W] !== exp[i]) bad++;
                check("load_grant_id", grant_id, id);
                check("load_bad_bands", bad, 0);
                check("load_req_ready", req_ready, stall ? 0 : (1 << id));
                if (!stall) seen = 1'b1;
            end else begin
                check("wait_req_ready", req_ready, 0);
            end
            if (!seen) @(negedge clk);
        end
        check("frame_taken", seen, 1);
        if (!seen) return;
        rr_last = id;
        @(negedge clk);
        stall = 1'b0;
        if (refill) load_frame(id, 1'b0);
        else        req_valid[id] = 1'b0;

        b    = 0;
        done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            if (rst_at >= 0 && b == rst_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                #1;
                bad = 0;
                for (int i = 0; i < NB; i++) if (ser_in[i*W +: W] !== '0) bad++;
                check("rst_busy", busy, 0);
                check("rst_s_valid", ser_s_valid, 0);
                check("rst_req_ready", req_ready, 0);
                check("rst_grant_id", grant_id, 0);
                check("rst_frame_count", frame_count, 0);
                check("rst_ser_in_nonzero", bad, 0);
                reset_n   = 1'b1;
                rr_last   = NR - 1;
                exp_count = 0;
                return;
            end
            if (drop_en_at >= 0 && b == drop_en_at) enable = 1'b0;
            ser_m_ready = (bp == 0) ? 1'b1 : (bp == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            #1;
            check("drain_req_ready", req_ready, 0);
            check("drain_s_valid", ser_s_valid, 0);
            if (ser_m_valid && ser_m_ready) begin
                check("beat_data", ser_m_data, exp[b]);
                check("beat_last", ser_m_last, (b == NB - 1));
                b++;
                if (ser_m_last || b == NB) done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        check("beat_count", b, NB);
        if (!done) return;
        exp_count = (exp_count + 1) & 16'hFFFF;

        for (int g = 1; g <= GAP + 1; g++) begin
            @(negedge clk);
            ser_m_ready = 1'($urandom_range(0, 1));
            #1;
            if (g == 1) check("frame_count", frame_count, exp_count);
            check("gap_busy", busy, (g <= GAP));
            check("gap_req_ready", req_ready, 0);
            check("gap_s_valid", ser_s_valid, 0);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        enable      = 1'b1;
        stall       = 1'b0;
        ser_m_ready = 1'b1;
        req_valid   = 2'b11;
        rr_last     = NR - 1;
        exp_count   = 0;
        load_frame(0, 1'b1);
        load_frame(1, 1'b0);

        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_busy", busy, 0);
            check("reset_s_valid", ser_s_valid, 0);
            check("reset_frame_count", frame_count, 0);
        end
        reset_n = 1'b1;

        // Ramp frame from producer 0 first, then producer 0 steps back.
        run_frame(0, -1, -1, 1'b0);

        // Both producers continuously valid.
        load_frame(0, 1'b0);
        req_valid = 2'b11;
        repeat (3) run_frame(2, -1, -1, 1'b1);

        run_frame(1, -1, -1, 1'b1);

        // Only producer 1; enable drops mid-drain.
        req_valid = 2'b10;
        run_frame(0, 20, -1, 1'b1);
        repeat (8) begin
            @(negedge clk);
            #1;
            check("disabled_busy", busy, 0);
            check("disabled_s_valid", ser_s_valid, 0);
        end
        enable = 1'b1;
        @(negedge clk);
        #1;
        check("reenable_s_valid", ser_s_valid, 1);
        check("reenable_grant_id", grant_id, 1);
        run_frame(0, -1, -1, 1'b1);

        // Reset on beat 20, then a clean frame from band 0.
        load_frame(0, 1'b0);
        req_valid = 2'b11;
        run_frame(0, -1, 20, 1'b1);
        run_frame(2, -1, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
